// File: rtl/bs5_bus_pkg.sv
// bs5_bus_pkg: shared definitions for the BackSlashFive system bus arbiter.
// Holds the default bus widths, the arbiter FSM encoding and the one-hot
// grant encodings used on the grant output.
package bs5_bus_pkg;

    localparam int unsigned ADDR_W_DEF         = 16;
    localparam int unsigned DATA_W_DEF         = 16;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arb_state_e;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    // Map a manager index (0 or 1) to its one-hot grant code.
    function automatic logic [1:0] gnt_of(input logic idx);
        return idx ? GNT_M1 : GNT_M0;
    endfunction

endpackage

// File: rtl/bus_rr_pick2.sv
// bus_rr_pick2: combinational two-way round-robin picker.
// A lone requester always wins; on a tie the manager that did not win last
// time is chosen, so continuous contention alternates between the two.
module bus_rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       valid_o,
    output logic       winner_o
);

    // Pick the winner index from the request vector and previous owner.
    always_comb begin
        valid_o  = |req_i;
        winner_o = 1'b0;
        unique case (req_i)
            2'b01:   winner_o = 1'b0;
            2'b10:   winner_o = 1'b1;
            2'b11:   winner_o = ~last_grant_i;
            default: winner_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/bus_arbiter2.sv
// bus_arbiter2: two-manager, one-subordinate round-robin arbiter placed in
// front of bus_ctrl. One transaction is in flight at a time; the winner's
// request is latched, replayed downstream, and ack/read data go back to the
// winner only.
// Optional build macro BUS_ARB_TIMEOUT_EN adds a BUSY watchdog that aborts a
// stalled transaction after TIMEOUT_CYCLES, returns zero data and pulses err.
module bus_arbiter2
    import bs5_bus_pkg::*;
#(
    parameter int unsigned ADDR_W         = ADDR_W_DEF,
    parameter int unsigned DATA_W         = DATA_W_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic              bus_clock,
    input  logic              reset,

    input  logic              m0_we,
    input  logic              m0_re,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_data_write,
    output logic [DATA_W-1:0] m0_data_read,
    output logic              m0_ack,
    output logic              m0_ready,

    input  logic              m1_we,
    input  logic              m1_re,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_data_write,
    output logic [DATA_W-1:0] m1_data_read,
    output logic              m1_ack,
    output logic              m1_ready,

    output logic              s_we,
    output logic              s_re,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_data_write,
    input  logic [DATA_W-1:0] s_data_read,
    input  logic              s_ack,
    input  logic              s_ready,

    output logic [1:0]        grant,
    output logic              err
);

    arb_state_e        state_q;
    arb_state_e        state_d;
    logic              last_grant_q;
    logic [1:0]        grant_q;
    logic              op_we_q;
    logic              op_re_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

    logic [1:0]        req;
    logic              pick_valid;
    logic              pick_winner;
    logic              start;
    logic              busy_ack;
    logic              abort;

    logic              sel_we;
    logic              sel_re;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign req = {m1_we | m1_re, m0_we | m0_re};

    bus_rr_pick2 u_pick (
        .req_i        (req),
        .last_grant_i (last_grant_q),
        .valid_o      (pick_valid),
        .winner_o     (pick_winner)
    );

    // Route the winning manager's request fields towards the capture registers.
    always_comb begin
        sel_we    = m0_we;
        sel_re    = m0_re;
        sel_addr  = m0_addr;
        sel_wdata = m0_data_write;
        if (pick_winner) begin
            sel_we    = m1_we;
            sel_re    = m1_re;
            sel_addr  = m1_addr;
            sel_wdata = m1_data_write;
        end
    end

    // Arbitration only happens in IDLE with the subordinate ready, so the
    // winner's request still held during DONE can never be granted twice.
    assign start    = (state_q == ST_IDLE) && s_ready && pick_valid;
    assign busy_ack = (state_q == ST_BUSY) && s_ack;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] busy_cnt_q;
    logic             abort_q;

    // A real s_ack on the last allowed cycle wins over the abort.
    assign abort = (state_q == ST_BUSY) && !s_ack &&
                   (busy_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Count BUSY cycles from zero for each transaction and flag the abort for DONE.
    always_ff @(posedge bus_clock or negedge reset) begin
        if (!reset) begin
            busy_cnt_q <= '0;
            abort_q    <= 1'b0;
        end else begin
            abort_q <= abort;
            if (start) begin
                busy_cnt_q <= '0;
            end else if (state_q == ST_BUSY) begin
                busy_cnt_q <= busy_cnt_q + 1'b1;
            end
        end
    end

    assign err = abort_q;
`else
    assign abort = 1'b0;
    assign err   = 1'b0;

    // TIMEOUT_CYCLES only matters with the watchdog built in; it is referenced
    // here so the parameter list is identical in both builds.
    if (TIMEOUT_CYCLES == 0) begin : g_timeout_param_unused
    end
`endif

    // FSM state register.
    always_ff @(posedge bus_clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic: IDLE -> BUSY on grant, BUSY -> DONE on ack or abort.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_BUSY;
            ST_BUSY: if (busy_ack || abort) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Latch the winner's request at grant time and capture read data at completion.
    always_ff @(posedge bus_clock or negedge reset) begin
        if (!reset) begin
            last_grant_q <= 1'b1;
            grant_q      <= GNT_NONE;
            op_we_q      <= 1'b0;
            op_re_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            if (start) begin
                last_grant_q <= pick_winner;
                grant_q      <= gnt_of(pick_winner);
                op_we_q      <= sel_we;
                op_re_q      <= sel_re & ~sel_we;
                addr_q       <= sel_addr;
                wdata_q      <= sel_wdata;
            end
            if (state_q == ST_DONE) begin
                grant_q <= GNT_NONE;
            end
            if (busy_ack || abort) begin
                if (grant_q == GNT_M1) begin
                    rdata1_q <= busy_ack ? s_data_read : '0;
                end else begin
                    rdata0_q <= busy_ack ? s_data_read : '0;
                end
            end
        end
    end

    // FSM outputs: strobes only in BUSY, ready only in IDLE, ack only in DONE.
    always_comb begin
        s_we     = (state_q == ST_BUSY) && op_we_q;
        s_re     = (state_q == ST_BUSY) && op_re_q;
        m0_ready = (state_q == ST_IDLE);
        m1_ready = (state_q == ST_IDLE);
        m0_ack   = (state_q == ST_DONE) && (grant_q == GNT_M0);
        m1_ack   = (state_q == ST_DONE) && (grant_q == GNT_M1);
    end

    assign s_addr       = addr_q;
    assign s_data_write = wdata_q;
    assign grant        = grant_q;
    assign m0_data_read = rdata0_q;
    assign m1_data_read = rdata1_q;

endmodule
